mem_bus_master: RTL and testbench

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

---
 rtl/mem_bus_master.sv | 237 +++++++++++++++++++++++
 tb/tb_mem_bus_master.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// Memory bus master: turns one byte/halfword/word/doubleword request into MOV/MOC
// handshakes with a word-wide RAM, with alignment checking and a handshake timeout.
module mem_bus_master #(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 8
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              req,
  input  logic              req_rw,
  input  logic [1:0]        req_type,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [63:0]       rdata,
  output logic              MOV,
  output logic              RW,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       DaIn,
  output logic [1:0]        typeData,
  input  logic [31:0]       DaOut,
  input  logic              MOC
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Halfwords need bit 0 clear; words and doublewords need bits [1:0] clear.
  function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] lsb);
    logic bad;
    case (typ)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lsb[0];
      default: bad = (lsb != 2'b00);
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] extend_read(input logic [1:0] typ, input logic sgn,
                                              input logic [31:0] d);
    logic [31:0] v;
    case (typ)
      2'b00:   v = {{24{sgn & d[7]}}, d[7:0]};
      2'b01:   v = {{16{sgn & d[15]}}, d[15:0]};
      default: v = d;
    endcase
    return v;
  endfunction

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                rw_r, rw_s;
  logic [1:0]          type_r, type_s;
  logic                signed_r, signed_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic [63:0]         wdata_r, wdata_s;
  logic                second_r, second_s;
  logic                mov_r, mov_s;
  logic                bus_rw_r, bus_rw_s;
  logic [ADDR_W-1:0]   bus_addr_r, bus_addr_s;
  logic [31:0]         dain_r, dain_s;
  logic [1:0]          tdata_r, tdata_s;
  logic                busy_r;
  logic                done_r, done_s;
  logic                err_r, err_s;
  logic [63:0]         rdata_r, rdata_s;
  logic                timeout_s;

  assign timeout_s = (cnt_r == CNT_LAST);

  // Next-state and next-output computation for the handshake FSM.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    rw_s       = rw_r;
    type_s     = type_r;
    signed_s   = signed_r;
    addr_s     = addr_r;
    wdata_s    = wdata_r;
    second_s   = second_r;
    mov_s      = mov_r;
    bus_rw_s   = bus_rw_r;
    bus_addr_s = bus_addr_r;
    dain_s     = dain_r;
    tdata_s    = tdata_r;
    done_s     = 1'b0;
    err_s      = 1'b0;
    rdata_s    = rdata_r;

    case (state_r)
      IDLE: begin
        if (req) begin
          rw_s     = req_rw;
          type_s   = req_type;
          signed_s = req_signed;
          addr_s   = req_addr;
          wdata_s  = req_wdata;
          second_s = 1'b0;
          rdata_s  = 64'd0;
          if (is_misaligned(req_type, req_addr[1:0])) begin
            state_s = DONE;
            done_s  = 1'b1;
            err_s   = 1'b1;
          end else begin
            state_s    = ISSUE;
            cnt_s      = '0;
            mov_s      = 1'b1;
            bus_rw_s   = req_rw;
            bus_addr_s = req_addr;
            dain_s     = req_rw ? 32'd0 : req_wdata[31:0];
            // A doubleword travels as two word accesses.
            tdata_s    = (req_type == 2'b11) ? 2'b10 : req_type;
          end
        end else begin
          state_s = IDLE;
        end
      end

      ISSUE: begin
        if (MOC) begin
          state_s = RELEASE;
          cnt_s   = '0;
          mov_s   = 1'b0;
          if (rw_r) begin
            if (second_r) begin
              rdata_s[63:32] = DaOut;
            end else begin
              rdata_s[31:0] = extend_read(type_r, signed_r, DaOut);
            end
          end else begin
            rdata_s = rdata_r;
          end
        end else if (timeout_s) begin
          state_s = DONE;
          mov_s   = 1'b0;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (!MOC) begin
          if ((type_r == 2'b11) && !second_r) begin
            state_s    = ISSUE;
            cnt_s      = '0;
            mov_s      = 1'b1;
            second_s   = 1'b1;
            bus_addr_s = addr_r + ADDR_W'(4);
            dain_s     = rw_r ? 32'd0 : wdata_r[63:32];
          end else begin
            state_s = DONE;
            done_s  = 1'b1;
          end
        end else if (timeout_s) begin
          state_s = DONE;
          done_s  = 1'b1;
          err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      DONE: begin
        state_s = IDLE;
      end

      default: begin
        state_s = IDLE;
        mov_s   = 1'b0;
      end
    endcase
  end

  // State and registered outputs; CLR overrides every other input.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      rw_r       <= 1'b1;
      type_r     <= 2'b00;
      signed_r   <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 64'd0;
      second_r   <= 1'b0;
      mov_r      <= 1'b0;
      bus_rw_r   <= 1'b1;
      bus_addr_r <= '0;
      dain_r     <= 32'd0;
      tdata_r    <= 2'b00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      rdata_r    <= 64'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      rw_r       <= rw_s;
      type_r     <= type_s;
      signed_r   <= signed_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      second_r   <= second_s;
      mov_r      <= mov_s;
      bus_rw_r   <= bus_rw_s;
      bus_addr_r <= bus_addr_s;
      dain_r     <= dain_s;
      tdata_r    <= tdata_s;
      busy_r     <= (state_s != IDLE);
      done_r     <= done_s;
      err_r      <= err_s;
      rdata_r    <= rdata_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;
  assign rdata    = rdata_r;
  assign MOV      = mov_r;
  assign RW       = bus_rw_r;
  assign address  = bus_addr_r;
  assign DaIn     = dain_r;
  assign typeData = tdata_r;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: a byte-array RAM with selectable MOC behaviour, directed
// corner cases and random requests checked against an arithmetic reference model.
module tb_mem_bus_master;
  localparam int TIMEOUT = 15;
  localparam int ADDR_W  = 8;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        req;
  logic        req_rw;
  logic [1:0]  req_type;
  logic        req_signed;
  logic [7:0]  req_addr;
  logic [63:0] req_wdata;
  logic        busy, done, err;
  logic [63:0] rdata;
  logic        MOV, RW;
  logic [7:0]  address;
  logic [31:0] DaIn;
  logic [1:0]  typeData;
  logic [31:0] DaOut;
  logic        MOC;

  // 0: MOC follows MOV, 1: MOC stuck low, 2: MOC stuck high
  logic [1:0]  moc_mode;
  logic [7:0]  mem [256];

  typedef struct packed {
    logic [7:0]  a;
    logic        rw;
    logic [31:0] d;
    logic [1:0]  t;
  } hs_t;
  hs_t hs_q[$];
  int  mov_cycles = 0;
  int  checks = 0;
  int  fails  = 0;

  mem_bus_master #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .CLR(CLR), .req(req), .req_rw(req_rw), .req_type(req_type),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .MOV(MOV), .RW(RW),
    .address(address), .DaIn(DaIn), .typeData(typeData), .DaOut(DaOut), .MOC(MOC)
  );

  always #5 CLK = ~CLK;

  assign MOC = (moc_mode == 2'd0) ? MOV : (moc_mode == 2'd2);

  always_comb begin
    DaOut = {mem[8'(address + 8'd3)], mem[8'(address + 8'd2)],
             mem[8'(address + 8'd1)], mem[address]};
  end

  always @(posedge CLK) begin
    if (MOV === 1'b1) mov_cycles <= mov_cycles + 1;
    if (MOV === 1'b1 && MOC === 1'b1) hs_q.push_back('{address, RW, DaIn, typeData});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [7:0] a);
    return mem[a] + (mem[8'(a + 8'd1)] * 256) + (mem[8'(a + 8'd2)] * 65536)
           + (mem[8'(a + 8'd3)] * 16777216);
  endfunction

  // Reference result: n_hs is how many word accesses actually completed.
  function automatic logic [63:0] model_rdata(input logic rw, input logic [1:0] typ,
                                              input logic sgn, input logic [7:0] a,
                                              input int n_hs);
    logic [31:0] v;
    logic [63:0] r;
    r = 64'd0;
    if (rw && n_hs > 0) begin
      case (typ)
        2'b00: begin
          v = 32'(mem[a]);
          if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
          r = {32'd0, v};
        end
        2'b01: begin
          v = 32'(mem[a]) + 32'(mem[8'(a + 8'd1)]) * 32'd256;
          if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
          r = {32'd0, v};
        end
        2'b10: r = {32'd0, ram_word(a)};
        default: begin
          r = {32'd0, ram_word(a)};
          if (n_hs > 1) r[63:32] = ram_word(8'(a + 8'd4));
        end
      endcase
    end
    return r;
  endfunction

  task automatic do_req(input string tag, input logic rw, input logic [1:0] typ,
                        input logic sgn, input logic [7:0] a, input logic [63:0] wd);
    logic mis;
    int n, exp_n, exp_hs, exp_mc, hs0, mc0;
    hs_t exp_e;
    mis = (typ == 2'b01 && a[0] == 1'b1) || (typ[1] == 1'b1 && a[1:0] != 2'b00);
    @(negedge CLK);
    req = 1'b1; req_rw = rw; req_type = typ; req_signed = sgn; req_addr = a; req_wdata = wd;
    hs0 = hs_q.size();
    mc0 = mov_cycles;
    @(posedge CLK);
    #1;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      req        = 1'($urandom);
      req_rw     = 1'($urandom);
      req_type   = 2'($urandom);
      req_addr   = 8'($urandom);
      req_wdata  = {$urandom, $urandom};
      @(posedge CLK);
      #1;
      n++;
    end
    req = 1'b0;
    if (mis) begin
      exp_n = 0; exp_hs = 0;
    end else if (moc_mode == 2'd0) begin
      exp_n  = (typ == 2'b11) ? 4 : 2;
      exp_hs = (typ == 2'b11) ? 2 : 1;
    end else if (moc_mode == 2'd1) begin
      exp_n = TIMEOUT; exp_hs = 0;
    end else begin
      exp_n = TIMEOUT + 1; exp_hs = 1;
    end
    exp_mc = (!mis && moc_mode == 2'd1) ? TIMEOUT : exp_hs;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(exp_n));
    chk({tag, "_err"}, 64'(err), 64'(mis || moc_mode != 2'd0));
    chk({tag, "_rdata"}, rdata, model_rdata(rw, typ, sgn, a, exp_hs));
    chk({tag, "_hs_count"}, 64'(hs_q.size() - hs0), 64'(exp_hs));
    chk({tag, "_mov_cycles"}, 64'(mov_cycles - mc0), 64'(exp_mc));
    for (int k = 0; k < exp_hs && hs0 + k < hs_q.size(); k++) begin
      exp_e.a  = 8'(a + 8'(4 * k));
      exp_e.rw = rw;
      exp_e.d  = rw ? 32'd0 : ((k == 0) ? wd[31:0] : wd[63:32]);
      exp_e.t  = (typ == 2'b11) ? 2'b10 : typ;
      chk({tag, "_hs"}, 64'(hs_q[hs0 + k]), 64'(exp_e));
    end
    @(posedge CLK);
    #1;
    chk({tag, "_done_pulse"}, 64'({done, busy}), 64'd0);
  endtask

  initial begin
    logic       seen_done;
    logic [1:0] t;
    logic [7:0] a;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[3] = 8'h80;
    moc_mode = 2'd0;
    CLR = 1'b1; req = 1'b0; req_rw = 1'b1; req_type = 2'b00; req_signed = 1'b0;
    req_addr = 8'd0; req_wdata = 64'd0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_bus", 64'({MOV, RW, address, DaIn, typeData}), 64'({1'b0, 1'b1, 8'd0, 32'd0, 2'b00}));
    chk("reset_status", 64'({busy, done, err}), 64'd0);
    chk("reset_rdata", rdata, 64'd0);
    @(negedge CLK);
    CLR = 1'b0;

    do_req("rd_byte_signed", 1'b1, 2'b00, 1'b1, 8'h03, 64'd0);
    chk("rd_byte_signed_const", rdata, 64'h0000_0000_FFFF_FF80);
    do_req("rd_byte_unsigned", 1'b1, 2'b00, 1'b0, 8'h03, 64'd0);
    chk("rd_byte_unsigned_const", rdata, 64'h0000_0000_0000_0080);
    do_req("wr_dword_wrap", 1'b0, 2'b11, 1'b0, 8'hFC, 64'h1122_3344_AABB_CCDD);
    do_req("rd_word_misaligned", 1'b1, 2'b10, 1'b0, 8'h06, 64'd0);
    do_req("rd_dword_wrap", 1'b1, 2'b11, 1'b0, 8'hFC, 64'd0);

    moc_mode = 2'd1;
    do_req("issue_timeout", 1'b1, 2'b10, 1'b0, 8'h40, 64'd0);
    moc_mode = 2'd2;
    do_req("release_timeout", 1'b1, 2'b11, 1'b0, 8'h08, 64'd0);
    moc_mode = 2'd0;

    for (int i = 0; i < 40; i++) begin
      t = 2'($urandom);
      a = 8'($urandom);
      if ($urandom_range(3, 0) != 0) a = a & ((t == 2'b00) ? 8'hFF : (t == 2'b01) ? 8'hFE : 8'hFC);
      do_req("random", 1'($urandom), t, 1'($urandom), a, {$urandom, $urandom});
    end

    // Abort a dword read while it waits in ISSUE.
    moc_mode = 2'd1;
    @(negedge CLK);
    req = 1'b1; req_rw = 1'b1; req_type = 2'b11; req_addr = 8'h20;
    @(posedge CLK);
    #1;
    req = 1'b0;
    chk("abort_mov_before", 64'(MOV), 64'd1);
    @(negedge CLK);
    CLR = 1'b1; req = 1'b1;
    @(posedge CLK);
    #1;
    chk("abort_after_clr", 64'({MOV, busy, done, err}), 64'd0);
    @(negedge CLK);
    CLR = 1'b0; req = 1'b0;
    seen_done = 1'b0;
    repeat (4) begin
      @(posedge CLK);
      #1;
      seen_done = seen_done | done | busy;
    end
    chk("abort_quiet", 64'(seen_done), 64'd0);
    moc_mode = 2'd0;
    do_req("after_abort_rd", 1'b1, 2'b10, 1'b0, 8'h10, 64'd0);
    chk("after_abort_const", rdata, 64'(ram_word(8'h10)));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
